button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Front-end conditioning stage for the board push-buttons: raw active-low button pins in, clean single-cycle press/release pulses and debounced levels out.
- Sits directly upstream of the seven-segment counter/position control logic; its `btn_press` pulses drive count and digit stepping.
- Per-button hold-to-repeat, so a held button generates repeated step pulses.
- Each button is handled independently by its own synchronizer, counter and FSM.

Parameters:
- NUM_BTN, 4, number of buttons handled.
- DEBOUNCE_CYCLES, 500_000, stable-sample count required to accept a press or release; 10 ms at 50 MHz; must be >= 1.
- REPEAT_DELAY, 25_000_000, cycles from the press pulse to the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 5_000_000, cycles between subsequent repeat pulses; must be >= 1.
- REPEAT_MASK, 4'b0011, bit i = 1 enables auto-repeat for button i.

Ports:
- clk_arg  input  1  system clock.
- rstn  input  1  asynchronous, active-low reset.
- btn_n  input  NUM_BTN  raw button pins, 0 = pushed, asynchronous to clk_arg.
- btn_level  output  NUM_BTN  debounced state, 1 = pushed.
- btn_press  output  NUM_BTN  one-cycle pulse on accepted press and on each repeat.
- btn_release  output  NUM_BTN  one-cycle pulse on accepted release.
- any_press  output  1  OR of btn_press, registered in the same cycle as btn_press.

Behaviour:
- Reset (rstn = 0, asynchronous):
  - Both synchronizer flops per button go to 1 (released).
  - All FSMs go to IDLE and all counters to 0.
  - btn_level, btn_press, btn_release and any_press are all 0.
- Synchronizer: 2-FF per bit on btn_n. `s` is the second-stage output. All FSM decisions use `s` only.
- Counter: 32-bit per button, cnt, cleared on every state change.
- FSM per button. States IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB. Transitions are evaluated on each clk_arg rising edge.
  - IDLE: s = 0 -> PRESS_DB.
  - PRESS_DB:
    - s = 1 -> IDLE, no pulse (glitch rejected).
    - Else if cnt == DEBOUNCE_CYCLES-1 -> HELD, btn_level <= 1, btn_press pulse.
    - Else cnt++.
  - HELD:
    - s = 1 -> RELEASE_DB.
    - Else if REPEAT_MASK[i] and cnt == REPEAT_DELAY-1 -> REPEAT, btn_press pulse.
    - Else cnt++. If the mask bit is clear, cnt saturates instead of wrapping.
  - REPEAT:
    - s = 1 -> RELEASE_DB.
    - Else if cnt == REPEAT_PERIOD-1 -> btn_press pulse, cnt <= 0, stay in REPEAT.
    - Else cnt++.
  - RELEASE_DB:
    - s = 0 -> HELD, cnt <= 0, no pulse. btn_level stays 1 and the repeat delay restarts.
    - Else if cnt == DEBOUNCE_CYCLES-1 -> IDLE, btn_level <= 0, btn_release pulse.
    - Else cnt++.
  - No btn_press pulses are issued in RELEASE_DB.
- Latency, with edge 0 = first rising edge at which btn_n[i] is sampled at its new value:
  - PRESS_DB or RELEASE_DB is entered at edge 2.
  - btn_press or btn_release is high for the single cycle following edge DEBOUNCE_CYCLES+2.
  - btn_level changes at that same edge.
  - First repeat pulse: REPEAT_DELAY cycles after the press pulse. Subsequent repeats: every REPEAT_PERIOD cycles.
- Output rules:
  - All outputs are registered.
  - btn_press and btn_release are never high in the same cycle for the same button.
  - Pulses are never longer than 1 cycle.
- Simultaneous buttons: fully independent; several btn_press bits may be high in one cycle.
- Reset mid-operation:
  - Any pending pulse is lost; no release pulse is generated.
  - If a button is still held at deassertion, it is treated as a fresh press: a btn_press pulse appears DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.

Test Plan (NUM_BTN=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=4'b0011):
1. Reset, btn_n = 4'hF for 50 cycles -> all outputs 0 throughout; rstn low mid-run forces all outputs 0 asynchronously.
2. btn_n[0] low for 3 cycles, then high -> no btn_press, btn_level[0] stays 0. btn_n[0] then held low -> btn_press[0] and any_press pulse 1 cycle following edge 6; btn_level[0] = 1 from edge 6.
3. Hold btn_n[1] low 40 cycles -> btn_press[1] pulses following edges 6, 16, 19, 22, ... every 3 until release. On release, btn_release[1] pulses following edge 6 after release; btn_level[1] = 0.
4. Hold btn_n[2] low 40 cycles (mask bit clear) -> exactly one btn_press[2] pulse, at edge 6. Release -> one btn_release[2].
5. While btn_level[0] = 1, raise btn_n[0] for 2 cycles, then low again -> no btn_release[0], btn_level[0] stays 1, next repeat pulse 10 cycles after return to HELD.
6. btn_n[0] and btn_n[3] pressed on the same edge -> btn_press = 4'b1001 in one cycle. Assert rstn low while both are held, deassert with both still held -> outputs 0 during reset, then btn_press = 4'b1001 again 6 cycles after the first post-reset edge.

Source files
------------

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-button synchronizer, debounce FSM and hold-to-repeat pulse generator
module button_debouncer #(
    parameter int                 NUM_BTN         = 4,
    parameter int                 DEBOUNCE_CYCLES = 500_000,
    parameter int                 REPEAT_DELAY    = 25_000_000,
    parameter int                 REPEAT_PERIOD   = 5_000_000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0011
) (
    input  logic               clk_arg,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RP_LAST  = 32'(REPEAT_PERIOD - 1);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        RELEASE_DB
    } state_t;

    // Press pulse being launched at this edge; lets any_press register alongside btn_press.
    logic [NUM_BTN-1:0] fire;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic   sync1;
        logic   s;
        state_t state;
        logic [31:0] cnt;
        logic   level;
        logic   press;
        logic   rel;

        // Reset to 1 so a pin already held at reset release reads as a fresh press.
        always_ff @(posedge clk_arg or negedge rstn) begin
            if (!rstn) begin
                sync1 <= 1'b1;
                s     <= 1'b1;
            end else begin
                sync1 <= btn_n[i];
                s     <= sync1;
            end
        end

        assign fire[i] = !s && (((state == PRESS_DB) && (cnt == DB_LAST)) ||
                                ((state == HELD) && REPEAT_MASK[i] && (cnt == RD_LAST)) ||
                                ((state == REPEAT) && (cnt == RP_LAST)));

        always_ff @(posedge clk_arg or negedge rstn) begin
            if (!rstn) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!s) begin
                            state <= PRESS_DB;
                            cnt   <= '0;
                        end
                    end
                    PRESS_DB: begin
                        if (s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state <= HELD;
                            cnt   <= '0;
                            level <= 1'b1;
                            press <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    HELD: begin
                        if (s) begin
                            state <= RELEASE_DB;
                            cnt   <= '0;
                        end else if (REPEAT_MASK[i] && (cnt == RD_LAST)) begin
                            state <= REPEAT;
                            cnt   <= '0;
                            press <= 1'b1;
                        end else if (REPEAT_MASK[i] || (cnt != CNT_MAX)) begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    REPEAT: begin
                        if (s) begin
                            state <= RELEASE_DB;
                            cnt   <= '0;
                        end else if (cnt == RP_LAST) begin
                            cnt   <= '0;
                            press <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    RELEASE_DB: begin
                        // A bounce back to pushed keeps the level and restarts the repeat delay.
                        if (!s) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                            rel   <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level;
        assign btn_press[i]   = press;
        assign btn_release[i] = rel;
    end

    always_ff @(posedge clk_arg or negedge rstn) begin
        if (!rstn) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |fire;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer with short debounce/repeat timings
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] btn_n = 4'hF;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       any_press;

    button_debouncer #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (4'b0011)
    ) dut (
        .clk_arg    (clk),
        .rstn       (rstn),
        .btn_n      (btn_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] set;
        logic [3:0] clr;
    } ev_t;

    ev_t sb[$];

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] st, input logic [3:0] cl);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.set = st; e.clr = cl;
        sb.push_back(e);
    endtask

    task automatic push_rep(input int b, input int first, input int last);
        logic [3:0] m;
        m = 4'(1 << b);
        for (int e = first; e <= last; e += 3) push(e, m, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    logic [3:0] exp_level = 4'h0;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;

    // Output at negedge k reflects rising edge k; events are keyed by that edge index.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_level = 4'h0;
            check("rst_level", 32'(btn_level), 32'h0);
            check("rst_press", 32'(btn_press), 32'h0);
            check("rst_release", 32'(btn_release), 32'h0);
            check("rst_any", 32'(any_press), 32'h0);
        end else begin
            exp_press = 4'h0;
            exp_rel   = 4'h0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].cyc == cyc) begin
                    exp_press |= sb[k].press;
                    exp_rel   |= sb[k].rel;
                    exp_level  = (exp_level | sb[k].set) & ~sb[k].clr;
                    sb.delete(k);
                end
            end
            check("btn_press", 32'(btn_press), 32'(exp_press));
            check("btn_release", 32'(btn_release), 32'(exp_rel));
            check("btn_level", 32'(btn_level), 32'(exp_level));
            check("any_press", 32'(any_press), 32'(|exp_press));
        end
    end

    int t0, g, m, h, r, q;

    initial begin
        // Reset, then idle with an asynchronous reset pulse mid-run
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_to(cyc + 25);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check("async_idle_level", 32'(btn_level), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        wait_to(cyc + 25);

        // Short glitch on button 0 rejected
        g = cyc;
        btn_n[0] = 1'b0;
        wait_to(g + 3);
        btn_n[0] = 1'b1;

        // Button 0 press, repeats, 2-cycle release bounce, then real release
        wait_to(g + 15);
        t0 = cyc;
        m  = t0 + 20;
        h  = m + 5;
        r  = h + 20;
        push(t0 + 7, 4'b0001, 4'h0, 4'b0001, 4'h0);
        push_rep(0, t0 + 17, m + 2);
        push_rep(0, h + 10, r + 2);
        push(r + 7, 4'h0, 4'b0001, 4'h0, 4'b0001);
        btn_n[0] = 1'b0;
        wait_to(m);
        btn_n[0] = 1'b1;
        wait_to(m + 2);
        btn_n[0] = 1'b0;
        wait_to(r);
        btn_n[0] = 1'b1;
        wait_to(r + 15);

        // Button 1 held 40 cycles with auto-repeat
        t0 = cyc;
        push(t0 + 7, 4'b0010, 4'h0, 4'b0010, 4'h0);
        push_rep(1, t0 + 17, t0 + 42);
        push(t0 + 47, 4'h0, 4'b0010, 4'h0, 4'b0010);
        btn_n[1] = 1'b0;
        wait_to(t0 + 40);
        btn_n[1] = 1'b1;
        wait_to(t0 + 55);

        // Button 2 held 40 cycles, repeat disabled
        t0 = cyc;
        push(t0 + 7, 4'b0100, 4'h0, 4'b0100, 4'h0);
        push(t0 + 47, 4'h0, 4'b0100, 4'h0, 4'b0100);
        btn_n[2] = 1'b0;
        wait_to(t0 + 40);
        btn_n[2] = 1'b1;
        wait_to(t0 + 55);

        // Buttons 0 and 3 together, reset while held, fresh press after reset
        t0 = cyc;
        push(t0 + 7, 4'b1001, 4'h0, 4'b1001, 4'h0);
        btn_n[0] = 1'b0;
        btn_n[3] = 1'b0;
        wait_to(t0 + 12);
        @(posedge clk);
        #2 rstn = 1'b0;
        sb.delete();
        #1 check("async_held_level", 32'(btn_level), 32'h0);
        check("async_held_any", 32'(any_press), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        r = cyc;
        q = r + 25;
        push(r + 7, 4'b1001, 4'h0, 4'b1001, 4'h0);
        push_rep(0, r + 17, q + 2);
        push(q + 7, 4'h0, 4'b1001, 4'h0, 4'b1001);
        wait_to(q);
        btn_n[0] = 1'b1;
        btn_n[3] = 1'b1;
        wait_to(q + 15);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
